// File: rtl/mat_vec_mul_stream.sv
// ---------------------------------------------------------------------------
// mat_vec_mul_stream
//
// Iterative matrix-vector multiplier with valid/ready handshakes on both
// sides. One MAT_ROW x MAT_COL matrix and one MAT_COL vector are latched per
// transaction, then MAT_ROW parallel MAC lanes consume one column per cycle.
// The full-precision result vector is presented on a valid/ready channel.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands valid
//   in_ready     block can accept operands (IDLE only)
//   signed_mode  1 = two's-complement operands, 0 = unsigned; latched on accept
//   mat          matrix operand, mat[row][col]
//   vec          vector operand, vec[col]
//   out_valid    result valid (DONE only)
//   out_ready    downstream accepts result
//   res          result vector, ACC_WIDTH per element
//   ovf          per-row clamp flag (saturating build only, else 0)
//
// Build option:
//   MVM_SATURATE_EN  when defined, each result element is clamped to the
//                    DATA_WIDTH range of the latched mode and ovf reports
//                    which rows were clamped. Latency is unchanged.
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for operands, in_ready = 1
//   COMPUTE | one MAC column per cycle, col = 0 .. MAT_COL-1
//   DONE    | result presented, out_valid = 1, held until out_ready
// ---------------------------------------------------------------------------
module mat_vec_mul_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int MAT_ROW    = 4,
    parameter int MAT_COL    = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAT_COL) + 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic                                          signed_mode,
    input  logic [0:MAT_ROW-1][0:MAT_COL-1][DATA_WIDTH-1:0] mat,
    input  logic [0:MAT_COL-1][DATA_WIDTH-1:0]            vec,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [0:MAT_ROW-1][ACC_WIDTH-1:0]             res,
    output logic [MAT_ROW-1:0]                            ovf
);

    // Column counter needs at least one bit even when MAT_COL == 1.
    localparam int COL_W  = (MAT_COL > 1) ? $clog2(MAT_COL) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAT_COL - 1);

    // Operands are extended by one bit (sign or zero) so a single signed
    // multiplier covers both modes; the exact product fits in 2*DATA_WIDTH+1
    // signed bits, so PROD_W has one bit of slack.
    localparam int PROD_W = 2*DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [0:MAT_ROW-1][0:MAT_COL-1][DATA_WIDTH-1:0] mat_q;
    logic [0:MAT_COL-1][DATA_WIDTH-1:0]              vec_q;
    logic                                            smode_q;
    logic [COL_W-1:0]                                col;
    logic signed [ACC_WIDTH-1:0]                     acc_q   [MAT_ROW];
    logic signed [ACC_WIDTH-1:0]                     acc_nxt [MAT_ROW];
    logic signed [PROD_W-1:0]                        prod    [MAT_ROW];
    logic signed [ACC_WIDTH-1:0]                     res_d   [MAT_ROW];
    logic [0:MAT_ROW-1][ACC_WIDTH-1:0]               res_q;
    logic                                            accept;
    logic                                            last_col;

    assign accept   = (state == IDLE) && in_valid;
    assign last_col = (col == COL_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = COMPUTE;
            COMPUTE: if (last_col)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // MAC lanes: one product per row for the current column
    // -----------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < MAT_ROW; r++) begin
            prod[r] = PROD_W'($signed({smode_q & mat_q[r][col][DATA_WIDTH-1], mat_q[r][col]}))
                    * PROD_W'($signed({smode_q & vec_q[col][DATA_WIDTH-1], vec_q[col]}));
            acc_nxt[r] = acc_q[r] + ACC_WIDTH'(prod[r]);
        end
    end

`ifdef MVM_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_SMAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_SMIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_UMAX =
        {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    logic [MAT_ROW-1:0] ovf_d;
    logic [MAT_ROW-1:0] ovf_q;

    // A signed value fits DATA_WIDTH when all bits from DATA_WIDTH-1 up are
    // identical; an unsigned value fits when all bits from DATA_WIDTH up are 0.
    always_comb begin
        for (int r = 0; r < MAT_ROW; r++) begin
            ovf_d[r] = 1'b0;
            res_d[r] = acc_nxt[r];
            if (smode_q) begin
                if (!(&acc_nxt[r][ACC_WIDTH-1:DATA_WIDTH-1]) &&
                     (|acc_nxt[r][ACC_WIDTH-1:DATA_WIDTH-1])) begin
                    ovf_d[r] = 1'b1;
                    res_d[r] = acc_nxt[r][ACC_WIDTH-1] ? SAT_SMIN : SAT_SMAX;
                end
            end else if (|acc_nxt[r][ACC_WIDTH-1:DATA_WIDTH]) begin
                ovf_d[r] = 1'b1;
                res_d[r] = SAT_UMAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if ((state == COMPUTE) && last_col) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    always_comb begin
        for (int r = 0; r < MAT_ROW; r++) begin
            res_d[r] = acc_nxt[r];
        end
    end

    assign ovf = '0;
`endif

    // -----------------------------------------------------------------------
    // Operand capture (pure datapath, no reset needed)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            mat_q <= mat;
            vec_q <= vec;
        end
    end

    // -----------------------------------------------------------------------
    // Control datapath: mode, column counter, accumulators, result
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            smode_q <= 1'b0;
            col     <= '0;
            res_q   <= '0;
            for (int r = 0; r < MAT_ROW; r++) begin
                acc_q[r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        smode_q <= signed_mode;
                        col     <= '0;
                        for (int r = 0; r < MAT_ROW; r++) begin
                            acc_q[r] <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    for (int r = 0; r < MAT_ROW; r++) begin
                        acc_q[r] <= acc_nxt[r];
                    end
                    if (last_col) begin
                        col <= '0;
                        for (int r = 0; r < MAT_ROW; r++) begin
                            res_q[r] <= res_d[r];
                        end
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign res = res_q;

endmodule
